// File: rtl/md6_param_rx_pkg.sv
// Shared constants and elaboration-time helpers for the MD6 parameter loader.
// Field indices follow the order in which the fields arrive on the wire.
package md6_rx_pkg;

  localparam int FLD_M      = 0;
  localparam int FLD_D      = 1;
  localparam int FLD_K      = 2;
  localparam int FLD_L      = 3;
  localparam int FLD_R      = 4;
  localparam int FLD_KEYLEN = 5;
  localparam int FLD_PAD    = 6;
  localparam int FLD_IDXP   = 7;

  localparam int D_W      = 16;
  localparam int L_W      = 8;
  localparam int R_W      = 16;
  localparam int KEYLEN_W = 8;
  localparam int PAD_W    = 16;
  localparam int IDXP_W   = 8;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic       {LD_LOAD, LD_HOLD} ld_state_t;

  // Message and key plus the nine bytes of the fixed-width fields.
  function automatic int total_bytes(input int msg_bytes, input int key_bytes);
    return msg_bytes + key_bytes + 9;
  endfunction

  function automatic int baud_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/md6_param_rx_if.sv
// Parameter-set bus between the UART loader (master) and the MD6 control (slave).
interface md6_param_rx_if #(
  parameter int MSG_BYTES = 512,
  parameter int KEY_BYTES = 64
);
  logic [8*MSG_BYTES-1:0] Message;
  logic [8*KEY_BYTES-1:0] K;
  logic [15:0]            d;
  logic [7:0]             L;
  logic [15:0]            r;
  logic [7:0]             keylen;
  logic [15:0]            padding_zero_M;
  logic [7:0]             index_padd;
  logic [7:0]             field_done;
  logic                   frame_valid;
  logic                   frame_ready;
  logic                   frame_err;
  logic                   overrun;

  modport master (
    output Message, K, d, L, r, keylen, padding_zero_M, index_padd,
    output field_done, frame_valid, frame_err, overrun,
    input  frame_ready
  );

  modport slave (
    input  Message, K, d, L, r, keylen, padding_zero_M, index_padd,
    input  field_done, frame_valid, frame_err, overrun,
    output frame_ready
  );
endinterface

// File: rtl/md6_param_rx_uart_rx_core.sv
// Oversampling 8N1 UART receiver: synchroniser, baud tick and START/DATA/STOP FSM.
// Emits a one-cycle byte_valid or frame_error pulse at the stop-bit mid-point.
module uart_rx_core
  import md6_rx_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rxd,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data,
  output logic       o_frame_error
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
  localparam logic [OSW-1:0] OS_MID   = OSW'(OVERSAMPLE/2 - 1);
  localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);

  generate
    if (DIV < 1) begin : g_div_chk
      $error("uart_rx_core: baud divider must be at least 1");
    end
    if (OVERSAMPLE < 4 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_os_chk
      $error("uart_rx_core: OVERSAMPLE must be a power of two >= 4");
    end
  endgenerate

  logic            r_sync1, r_sync2;
  logic [DCW-1:0]  r_div_cnt;
  logic            w_tick;
  rx_state_t       r_state;
  logic [OSW-1:0]  r_os_cnt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_byte_valid;
  logic            r_frame_error;

  // Synchroniser resets high so a reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rxd;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      r_div_cnt <= '0;
    else if (r_div_cnt == DIV_LAST) r_div_cnt <= '0;
    else                            r_div_cnt <= r_div_cnt + 1'b1;
  end

  assign w_tick = (r_div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= RX_IDLE;
      r_os_cnt      <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_byte_valid  <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_byte_valid  <= 1'b0;
      r_frame_error <= 1'b0;
      if (w_tick) begin
        case (r_state)
          RX_IDLE: begin
            if (!r_sync2) begin
              r_state  <= RX_START;
              r_os_cnt <= '0;
            end
          end
          RX_START: begin
            if (r_os_cnt == OS_MID) begin
              r_os_cnt  <= '0;
              r_bit_cnt <= '0;
              r_state   <= r_sync2 ? RX_IDLE : RX_DATA;
            end else begin
              r_os_cnt <= r_os_cnt + 1'b1;
            end
          end
          RX_DATA: begin
            if (r_os_cnt == OS_LAST) begin
              r_os_cnt  <= '0;
              r_shift   <= {r_sync2, r_shift[7:1]};
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == 3'd7) r_state <= RX_STOP;
            end else begin
              r_os_cnt <= r_os_cnt + 1'b1;
            end
          end
          RX_STOP: begin
            if (r_os_cnt == OS_LAST) begin
              r_os_cnt <= '0;
              r_state  <= RX_IDLE;
              if (r_sync2) r_byte_valid  <= 1'b1;
              else         r_frame_error <= 1'b1;
            end else begin
              r_os_cnt <= r_os_cnt + 1'b1;
            end
          end
          default: r_state <= RX_IDLE;
        endcase
      end
    end
  end

  assign o_byte_valid  = r_byte_valid;
  assign o_byte_data   = r_shift;
  assign o_frame_error = r_frame_error;

endmodule

// File: rtl/md6_param_rx.sv
// MD6 parameter loader: packs one serial batch into the field registers and
// holds the complete set until the MD6 control accepts it.
module md6_param_rx
  import md6_rx_pkg::*;
#(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD_RATE    = 115200,
  parameter int OVERSAMPLE   = 16,
  parameter int MSG_BYTES    = 512,
  parameter int KEY_BYTES    = 64,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          RxD,
  md6_param_rx_if.master frm
);

  localparam int TOTAL = total_bytes(MSG_BYTES, KEY_BYTES);
  localparam int PW    = $clog2(TOTAL);
  localparam int MIW   = $clog2(MSG_BYTES);
  localparam int KIW   = $clog2(KEY_BYTES);

  localparam logic [PW-1:0] P_D0      = PW'(MSG_BYTES);
  localparam logic [PW-1:0] P_M_END   = PW'(MSG_BYTES - 1);
  localparam logic [PW-1:0] P_D_END   = PW'(MSG_BYTES + 1);
  localparam logic [PW-1:0] P_K0      = PW'(MSG_BYTES + 2);
  localparam logic [PW-1:0] P_K_END   = PW'(MSG_BYTES + KEY_BYTES + 1);
  localparam logic [PW-1:0] P_L       = PW'(MSG_BYTES + KEY_BYTES + 2);
  localparam logic [PW-1:0] P_R0      = PW'(MSG_BYTES + KEY_BYTES + 3);
  localparam logic [PW-1:0] P_R_END   = PW'(MSG_BYTES + KEY_BYTES + 4);
  localparam logic [PW-1:0] P_KL      = PW'(MSG_BYTES + KEY_BYTES + 5);
  localparam logic [PW-1:0] P_PAD0    = PW'(MSG_BYTES + KEY_BYTES + 6);
  localparam logic [PW-1:0] P_PAD_END = PW'(MSG_BYTES + KEY_BYTES + 7);
  localparam logic [PW-1:0] P_IDX     = PW'(TOTAL - 1);

  localparam int TO_CLKS = TIMEOUT_BITS * baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE) * OVERSAMPLE;
  localparam int TW      = $clog2(TO_CLKS + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CLKS - 1);

  logic                   w_byte_valid;
  logic [7:0]             w_byte;
  logic                   w_frame_error;
  logic                   w_wr;
  logic [7:0]             w_fld_last;
  logic [PW-1:0]          w_k_off;
  logic [MIW-1:0]         w_m_idx;
  logic [KIW-1:0]         w_k_idx;

  ld_state_t              r_state;
  logic [PW-1:0]          r_ptr;
  logic [TW-1:0]          r_to_cnt;
  logic [7:0]             r_fdone;
  logic                   r_frame_valid;
  logic                   r_frame_err;
  logic                   r_overrun;
  logic [8*MSG_BYTES-1:0] r_msg;
  logic [8*KEY_BYTES-1:0] r_key;
  logic [D_W-1:0]         r_d;
  logic [L_W-1:0]         r_l;
  logic [R_W-1:0]         r_r;
  logic [KEYLEN_W-1:0]    r_keylen;
  logic [PAD_W-1:0]       r_pad;
  logic [IDXP_W-1:0]      r_idxp;

  uart_rx_core #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_rx (
    .clk           (clk),
    .reset         (reset),
    .i_rxd         (RxD),
    .o_byte_valid  (w_byte_valid),
    .o_byte_data   (w_byte),
    .o_frame_error (w_frame_error)
  );

  assign w_wr    = w_byte_valid && (r_state == LD_LOAD);
  assign w_k_off = r_ptr - P_K0;
  // Inverting the low three index bits makes each 64-bit word big-endian.
  assign w_m_idx = r_ptr[MIW-1:0] ^ MIW'(7);
  assign w_k_idx = w_k_off[KIW-1:0] ^ KIW'(7);

  always_comb begin
    w_fld_last             = '0;
    w_fld_last[FLD_M]      = (r_ptr == P_M_END);
    w_fld_last[FLD_D]      = (r_ptr == P_D_END);
    w_fld_last[FLD_K]      = (r_ptr == P_K_END);
    w_fld_last[FLD_L]      = (r_ptr == P_L);
    w_fld_last[FLD_R]      = (r_ptr == P_R_END);
    w_fld_last[FLD_KEYLEN] = (r_ptr == P_KL);
    w_fld_last[FLD_PAD]    = (r_ptr == P_PAD_END);
    w_fld_last[FLD_IDXP]   = (r_ptr == P_IDX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_msg    <= '0;
      r_key    <= '0;
      r_d      <= '0;
      r_l      <= '0;
      r_r      <= '0;
      r_keylen <= '0;
      r_pad    <= '0;
      r_idxp   <= '0;
    end else if (w_wr) begin
      if (r_ptr < P_D0)              r_msg[{w_m_idx, 3'b000} +: 8] <= w_byte;
      else if (r_ptr == P_D0)        r_d[7:0]                      <= w_byte;
      else if (r_ptr == P_D_END)     r_d[15:8]                     <= w_byte;
      else if (r_ptr <= P_K_END)     r_key[{w_k_idx, 3'b000} +: 8] <= w_byte;
      else if (r_ptr == P_L)         r_l                           <= w_byte;
      else if (r_ptr == P_R0)        r_r[7:0]                      <= w_byte;
      else if (r_ptr == P_R_END)     r_r[15:8]                     <= w_byte;
      else if (r_ptr == P_KL)        r_keylen                      <= w_byte;
      else if (r_ptr == P_PAD0)      r_pad[7:0]                    <= w_byte;
      else if (r_ptr == P_PAD_END)   r_pad[15:8]                   <= w_byte;
      else                           r_idxp                        <= w_byte;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= LD_LOAD;
      r_ptr         <= '0;
      r_to_cnt      <= '0;
      r_fdone       <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      case (r_state)
        LD_LOAD: begin
          if (w_byte_valid) begin
            r_fdone  <= r_fdone | w_fld_last;
            r_to_cnt <= '0;
            if (r_ptr == P_IDX) begin
              r_ptr         <= '0;
              r_state       <= LD_HOLD;
              r_frame_valid <= 1'b1;
            end else begin
              r_ptr <= r_ptr + 1'b1;
            end
          end else if (r_ptr != '0) begin
            // Inter-byte gap too long: drop the partial frame, keep the data.
            if (r_to_cnt == TO_LAST) begin
              r_to_cnt    <= '0;
              r_ptr       <= '0;
              r_fdone     <= '0;
              r_frame_err <= 1'b1;
            end else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end else begin
            r_to_cnt <= '0;
          end
          if (w_frame_error) r_frame_err <= 1'b1;
        end
        LD_HOLD: begin
          r_to_cnt <= '0;
          if (r_frame_valid && frm.frame_ready) begin
            r_state       <= LD_LOAD;
            r_frame_valid <= 1'b0;
            r_ptr         <= '0;
            r_fdone       <= '0;
            r_frame_err   <= 1'b0;
            r_overrun     <= 1'b0;
          end else if (w_byte_valid) begin
            r_overrun <= 1'b1;
          end
        end
        default: r_state <= LD_LOAD;
      endcase
    end
  end

  assign frm.Message        = r_msg;
  assign frm.K              = r_key;
  assign frm.d              = r_d;
  assign frm.L              = r_l;
  assign frm.r              = r_r;
  assign frm.keylen         = r_keylen;
  assign frm.padding_zero_M = r_pad;
  assign frm.index_padd     = r_idxp;
  assign frm.field_done     = r_fdone;
  assign frm.frame_valid    = r_frame_valid;
  assign frm.frame_err      = r_frame_err;
  assign frm.overrun        = r_overrun;

endmodule
